traffic_generator_gmii: RTL and testbench
=========================================

Name: traffic_generator_gmii

Overview:
- GMII transmit-side traffic source; the counterpart of the GMII traffic analyzer, running in the same clk domain.
- Sends back-to-back frames built from a 32-bit-word template RAM, with programmable frame size, inter-frame gap and frame count.
- Keeps sent-packet and sent-octet statistics.
- The CPU register block drives the control inputs and the template write port; gmii_* connect to the MAC/PHY or to the analyzer in loopback.

Parameters:
- C_TMPL_ADDR_WIDTH, 8, template RAM word-address width; capacity is 4*2^C_TMPL_ADDR_WIDTH bytes (1024 at default).
- C_MIN_IFG, 12, minimum inter-frame gap in idle clk cycles.

Ports:
- clk  in  1  byte clock.
- resetn  in  1  reset.
- run  in  1  level; 1 = generate frames.
- frame_size  in  16  frame length in bytes, excluding preamble.
- ifg  in  16  requested idle cycles between frames.
- frames_limit  in  32  frames per run; 0 = unlimited.
- err_inject  in  1  one-cycle pulse; arms gmii_er on the last byte of the next frame.
- clear_stats  in  1  one-cycle pulse; zeroes the counters.
- tmpl_wr  in  1  template write strobe.
- tmpl_addr  in  C_TMPL_ADDR_WIDTH  template word address.
- tmpl_data  in  32  template word; byte 0 of the word is bits [31:24].
- gmii_d  out  8  transmit data.
- gmii_en  out  1  transmit enable.
- gmii_er  out  1  transmit error.
- busy  out  1  1 while not in IDLE.
- done  out  1  frames_limit reached.
- pkts_sent  out  32  frames started.
- octets_sent  out  32  cycles with gmii_en=1.

Behaviour:
- Reset is synchronous, active-low on resetn; clock is clk.
- Reset values: gmii_d=0, gmii_en=0, gmii_er=0, busy=0, done=0, pkts_sent=0, octets_sent=0, state=IDLE, err_inject arm cleared.
- Reset asserted mid-frame: gmii_en=0 at the next edge; the frame is truncated and no counter update occurs.
- All gmii_* outputs are registered.
- Template RAM: single clock, 1-cycle read latency. Writes are allowed at any time; a write during transmit affects only bytes not yet read.
- Byte k of a frame = word k/4, byte lane k%4, MSB lane first.
- Effective size S = min(max(frame_size, 1), 4*2^C_TMPL_ADDR_WIDTH).
- Effective gap G = max(ifg, C_MIN_IFG).
- S, G and frames_limit are latched in the cycle a frame starts.
- States:
  - IDLE: if run=1 and done=0, go to FETCH.
  - FETCH: one cycle; reads word 0; goes to PRE if the macro is defined, else DATA.
  - PRE: 8 cycles, driving 0x55 x7 then 0xD5, with gmii_en=1.
  - DATA: S cycles, driving template bytes 0..S-1, with gmii_en=1.
  - GAP: G cycles, with gmii_en=0 and gmii_d=0.
- Timing: gmii_en rises exactly 2 cycles after the edge at which run=1 is sampled in IDLE. The first gmii_en cycle of a frame is the start of frame.
- GAP exit:
  - frames_limit≠0 and frames sent this run == frames_limit: set done=1, go to IDLE.
  - else run=0: go to IDLE.
  - else: go to FETCH. The next frame's gmii_en rises G+1 cycles after the previous frame's last byte.
- run deasserted mid-frame: the current frame and its GAP complete; no new frame starts.
- done: cleared when run=0 is sampled in IDLE. The run-frame counter resets on IDLE→FETCH from the done=0 state.
- err_inject: a pulse at any time sets the arm. gmii_er=1 (and gmii_en=1) on byte S-1 of the next DATA phase that has not yet reached byte S-1; the arm clears then. gmii_er=0 everywhere else.
- pkts_sent increments on the start-of-frame cycle.
- octets_sent increments on each gmii_en=1 cycle, preamble included.
- Both counters wrap modulo 2^32.
- clear_stats coincident with an increment: the result is 0 and the increment is lost.
- busy = (state≠IDLE).

Optional Feature:
- Macro: TRAFFIC_GENERATOR_GMII_PREAMBLE_EN.
- Defined: PRE state is present; 8 preamble/SFD bytes precede the data; each frame adds S+8 to octets_sent.
- Undefined: FETCH goes directly to DATA; gmii_en rises on template byte 0; each frame adds S to octets_sent.
- The 2-cycle run-to-gmii_en latency holds in both builds.

Test Plan:
- Template 0x00010203,0x04050607; frame_size=6, ifg=12, frames_limit=3; run=1 held. Expect:
  - 3 frames, each with data 00 01 02 03 04 05 (preceded by 55x7 D5 if the macro is defined).
  - Exactly 12 idle cycles between frames.
  - done=1; pkts_sent=3; octets_sent=18 (42 with the macro).
- ifg=2, frame_size=0: gaps are 12 cycles and each frame is 1 byte (0x00).
- frame_size=5000: 1024-byte frames.
- frames_limit=0, run=1; drop run to 0 at data byte 3 of frame 2, with frame_size=64. Expect:
  - Frame 2 completes all 64 bytes.
  - Full gap follows, then IDLE and busy=0.
  - pkts_sent=2.
- err_inject pulse during GAP: gmii_er=1 only on the last byte of the following frame and nowhere else; the next frame has gmii_er=0.
- resetn=0 at data byte 10: gmii_en=0 at the next edge; all outputs at reset values. After reset with run still 1: a fresh frame starts 2 cycles after reset release and pkts_sent=1.
- After 3 frames, pulse clear_stats: counters read 0. run=0 then 1: done clears and 3 new frames are sent.

Source files
------------

// File: rtl/traffic_generator_gmii.sv
// GMII transmit traffic source: template frames, gap, count, stats.
// Option: TRAFFIC_GENERATOR_GMII_PREAMBLE_EN adds 55x7+D5 before data.
module traffic_generator_gmii #(
  parameter int C_TMPL_ADDR_WIDTH = 8,
  parameter int C_MIN_IFG         = 12
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         run,
  input  logic [15:0]                  frame_size,
  input  logic [15:0]                  ifg,
  input  logic [31:0]                  frames_limit,
  input  logic                         err_inject,
  input  logic                         clear_stats,
  input  logic                         tmpl_wr,
  input  logic [C_TMPL_ADDR_WIDTH-1:0] tmpl_addr,
  input  logic [31:0]                  tmpl_data,
  output logic [7:0]                   gmii_d,
  output logic                         gmii_en,
  output logic                         gmii_er,
  output logic                         busy,
  output logic                         done,
  output logic [31:0]                  pkts_sent,
  output logic [31:0]                  octets_sent
);

  localparam int AW    = C_TMPL_ADDR_WIDTH;
  localparam int SW    = AW + 3;
  localparam int DEPTH = 1 << AW;

  localparam logic [SW-1:0] S_MAX = SW'(4 * DEPTH);
  localparam logic [15:0]   G_MIN = 16'(C_MIN_IFG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PRE,
    S_DATA,
    S_GAP
  } state_t;

`ifdef TRAFFIC_GENERATOR_GMII_PREAMBLE_EN
  localparam state_t S_FIRST = S_PRE;
`else
  localparam state_t S_FIRST = S_DATA;
`endif

  state_t        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [15:0]   gap_q, gap_d;
  logic [SW-1:0] s_q, s_d;
  logic [15:0]   g_q, g_d;
  logic [31:0]   lim_q, lim_d;
  logic [31:0]   run_cnt_q, run_cnt_d;
  logic          done_q, done_d;
  logic          arm_q, arm_d;
  logic [7:0]    gmii_d_q, gmii_d_d;
  logic          gmii_en_q, gmii_en_d;
  logic          gmii_er_q, gmii_er_d;
  logic [31:0]   pkts_q, pkts_d;
  logic [31:0]   oct_q, oct_d;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   rd_q;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic [SW-1:0] s_eff;
  logic [15:0]   g_eff;
  logic [7:0]    dbyte;
  logic          last;
  logic          latch;

  // Clamp requested size and gap to legal values
  always_comb begin
    s_eff = SW'(frame_size);
    if (frame_size == 16'd0) begin
      s_eff = SW'(1);
    end else if (32'(frame_size) > 32'(S_MAX)) begin
      s_eff = S_MAX;
    end
    g_eff = (ifg < G_MIN) ? G_MIN : ifg;
  end

  // Current template byte, MSB lane first
  always_comb begin
    dbyte = rd_q[{~cnt_q[1:0], 3'b000} +: 8];
    last  = (cnt_q == s_q - SW'(1));
  end

  // Next-state, wire outputs and statistics
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    s_d       = s_q;
    g_d       = g_q;
    lim_d     = lim_q;
    run_cnt_d = run_cnt_q;
    done_d    = done_q;
    arm_d     = arm_q;
    gmii_d_d  = 8'h00;
    gmii_en_d = 1'b0;
    gmii_er_d = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    latch     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!run) begin
          done_d = 1'b0;
        end else if (!done_q) begin
          state_d   = S_FETCH;
          run_cnt_d = 32'd1;
          latch     = 1'b1;
        end
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        cnt_d   = '0;
        state_d = S_FIRST;
      end
`ifdef TRAFFIC_GENERATOR_GMII_PREAMBLE_EN
      S_PRE: begin
        gmii_en_d = 1'b1;
        if (cnt_q == SW'(7)) begin
          gmii_d_d = 8'hD5;
          cnt_d    = '0;
          state_d  = S_DATA;
        end else begin
          gmii_d_d = 8'h55;
          cnt_d    = cnt_q + SW'(1);
        end
      end
`endif
      S_DATA: begin
        gmii_en_d = 1'b1;
        gmii_d_d  = dbyte;
        if (cnt_q[1:0] == 2'd3) begin
          rd_en   = 1'b1;
          rd_addr = cnt_q[AW+1:2] + AW'(1);
        end
        if (last) begin
          gmii_er_d = arm_q;
          arm_d     = 1'b0;
          gap_d     = '0;
          state_d   = S_GAP;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == g_q - 16'd1) begin
          if (lim_q != 32'd0 && run_cnt_q == lim_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (!run) begin
            state_d = S_IDLE;
          end else begin
            // last gap cycle doubles as the word-0 fetch,
            // so the wire sees exactly G idle cycles
            rd_en     = 1'b1;
            latch     = 1'b1;
            cnt_d     = '0;
            run_cnt_d = run_cnt_q + 32'd1;
            state_d   = S_FIRST;
          end
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (latch) begin
      s_d   = s_eff;
      g_d   = g_eff;
      lim_d = frames_limit;
    end

    if (err_inject) begin
      arm_d = 1'b1;
    end

    pkts_d = pkts_q + {31'd0, gmii_en_d & ~gmii_en_q};
    oct_d  = oct_q + {31'd0, gmii_en_d};
    if (clear_stats) begin
      pkts_d = '0;
      oct_d  = '0;
    end
  end

  // Template RAM, read-first, one-cycle read latency
  always_ff @(posedge clk) begin
    if (tmpl_wr) begin
      mem_q[tmpl_addr] <= tmpl_data;
    end
    if (rd_en) begin
      rd_q <= mem_q[rd_addr];
    end
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gap_q     <= '0;
      s_q       <= SW'(1);
      g_q       <= G_MIN;
      lim_q     <= '0;
      run_cnt_q <= '0;
      done_q    <= 1'b0;
      arm_q     <= 1'b0;
      gmii_d_q  <= 8'h00;
      gmii_en_q <= 1'b0;
      gmii_er_q <= 1'b0;
      pkts_q    <= '0;
      oct_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      s_q       <= s_d;
      g_q       <= g_d;
      lim_q     <= lim_d;
      run_cnt_q <= run_cnt_d;
      done_q    <= done_d;
      arm_q     <= arm_d;
      gmii_d_q  <= gmii_d_d;
      gmii_en_q <= gmii_en_d;
      gmii_er_q <= gmii_er_d;
      pkts_q    <= pkts_d;
      oct_q     <= oct_d;
    end
  end

  assign gmii_d      = gmii_d_q;
  assign gmii_en     = gmii_en_q;
  assign gmii_er     = gmii_er_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign pkts_sent   = pkts_q;
  assign octets_sent = oct_q;

endmodule

// File: tb/tb_traffic_generator_gmii.sv
// Directed bench for traffic_generator_gmii.
// Expected wire bytes are queued per frame and popped by a monitor.
module tb_traffic_generator_gmii;

`ifdef TRAFFIC_GENERATOR_GMII_PREAMBLE_EN
  localparam int PRE_LEN = 8;
`else
  localparam int PRE_LEN = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        run = 1'b0;
  logic [15:0] frame_size = '0;
  logic [15:0] ifg = '0;
  logic [31:0] frames_limit = '0;
  logic        err_inject = 1'b0;
  logic        clear_stats = 1'b0;
  logic        tmpl_wr = 1'b0;
  logic [7:0]  tmpl_addr = '0;
  logic [31:0] tmpl_data = '0;
  logic [7:0]  gmii_d;
  logic        gmii_en;
  logic        gmii_er;
  logic        busy;
  logic        done;
  logic [31:0] pkts_sent;
  logic [31:0] octets_sent;

  traffic_generator_gmii dut (
    .clk          (clk),
    .resetn       (resetn),
    .run          (run),
    .frame_size   (frame_size),
    .ifg          (ifg),
    .frames_limit (frames_limit),
    .err_inject   (err_inject),
    .clear_stats  (clear_stats),
    .tmpl_wr      (tmpl_wr),
    .tmpl_addr    (tmpl_addr),
    .tmpl_data    (tmpl_data),
    .gmii_d       (gmii_d),
    .gmii_en      (gmii_en),
    .gmii_er      (gmii_er),
    .busy         (busy),
    .done         (done),
    .pkts_sent    (pkts_sent),
    .octets_sent  (octets_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       er;
  } exp_t;

  exp_t        exp_q[$];
  int          gaps[$];
  logic [31:0] tmpl [256];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pkts = '0;
  logic [31:0] exp_oct = '0;
  bit          mon_on = 0;
  bit          have_prev = 0;
  bit          prev_en = 0;
  int          idle_cnt = 0;
  int          frames_seen = 0;
  int          byte_idx = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] tbyte(input int k);
    logic [31:0] w;
    w = tmpl[k/4];
    return w[8*(3-(k%4)) +: 8];
  endfunction

  task automatic push_frame(input int s, input bit er);
    exp_t e;
    for (int i = 0; i < PRE_LEN; i++) begin
      e.d  = (i == PRE_LEN-1) ? 8'hD5 : 8'h55;
      e.er = 1'b0;
      exp_q.push_back(e);
    end
    for (int k = 0; k < s; k++) begin
      e.d  = tbyte(k);
      e.er = er && (k == s-1);
      exp_q.push_back(e);
    end
    exp_pkts = exp_pkts + 32'd1;
    exp_oct  = exp_oct + 32'(s + PRE_LEN);
  endtask

  // Wire monitor: pops expected bytes, measures idle gaps
  always @(negedge clk) begin
    if (mon_on) begin
      if (gmii_en === 1'b1) begin
        if (!prev_en) begin
          frames_seen++;
          byte_idx = 0;
          if (have_prev) gaps.push_back(idle_cnt);
          have_prev = 1;
          idle_cnt  = 0;
        end
        byte_idx++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL extra_byte: observed=%0h expected=none",
                 gmii_d);
        end
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("gmii_d", 32'(gmii_d), 32'(e.d));
          chk("gmii_er", 32'(gmii_er), 32'(e.er));
        end
      end else begin
        idle_cnt++;
        chk("idle_wire", {23'd0, gmii_d, gmii_er}, 32'd0);
      end
      prev_en = (gmii_en === 1'b1);
    end
  end

  task automatic wr_word(input int a, input logic [31:0] v);
    @(negedge clk);
    tmpl_wr   = 1'b1;
    tmpl_addr = 8'(a);
    tmpl_data = v;
    tmpl[a]   = v;
    @(negedge clk);
    tmpl_wr = 1'b0;
  endtask

  task automatic start_run(input int fs, input int ig,
                           input int lim);
    @(negedge clk);
    run = 1'b0;
    gaps.delete();
    have_prev = 0;
    @(negedge clk);
    chk("done_clr", 32'(done), 32'd0);
    frame_size   = 16'(fs);
    ifg          = 16'(ig);
    frames_limit = 32'(lim);
    run          = 1'b1;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    repeat (2) @(negedge clk);
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic wait_en(input logic v, input int bound,
                         input string tag);
    int n;
    n = 0;
    while (gmii_en !== v && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(gmii_en), 32'(v));
  endtask

  task automatic chk_results();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("pkts_sent", pkts_sent, exp_pkts);
    chk("octets_sent", octets_sent, exp_oct);
  endtask

  task automatic chk_gaps(input int n, input int g);
    chk("gap_count", 32'(gaps.size()), 32'(n));
    while (gaps.size() != 0) begin
      chk("gap_len", 32'(gaps.pop_front()), 32'(g));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fb;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_en", 32'(gmii_en), 32'd0);
    chk("rst_d", 32'(gmii_d), 32'd0);
    chk("rst_er", 32'(gmii_er), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pkts", pkts_sent, 32'd0);
    chk("rst_oct", octets_sent, 32'd0);
    resetn = 1'b1;
    mon_on = 1;

    for (int a = 2; a < 256; a++) wr_word(a, $urandom);
    wr_word(0, 32'h00010203);
    wr_word(1, 32'h04050607);

    // three 6-byte frames, minimum gap
    for (int i = 0; i < 3; i++) push_frame(6, 0);
    start_run(6, 12, 3);
    @(negedge clk);
    chk("lat_c1", 32'(gmii_en), 32'd0);
    @(negedge clk);
    chk("lat_c2", 32'(gmii_en), 32'd0);
    @(negedge clk);
    chk("lat_c3", 32'(gmii_en), 32'd1);
    wait_idle(1000);
    chk_results();
    chk("done_set", 32'(done), 32'd1);
    chk_gaps(2, 12);

    // clear statistics
    @(negedge clk);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    chk("clr_pkts", pkts_sent, 32'd0);
    chk("clr_oct", octets_sent, 32'd0);
    exp_pkts = '0;
    exp_oct  = '0;

    // size 0 -> 1 byte, ifg below minimum
    for (int i = 0; i < 3; i++) push_frame(1, 0);
    start_run(0, 2, 3);
    wait_idle(1000);
    chk_results();
    chk("done_set2", 32'(done), 32'd1);
    chk_gaps(2, 12);

    // oversize clamps to full template
    push_frame(1024, 0);
    start_run(5000, 12, 1);
    wait_idle(3000);
    chk_results();

    // error injection during a gap
    push_frame(6, 0);
    push_frame(6, 1);
    push_frame(6, 0);
    start_run(6, 20, 3);
    wait_en(1'b1, 50, "err_f1_start");
    wait_en(1'b0, 50, "err_f1_end");
    repeat (3) @(negedge clk);
    err_inject = 1'b1;
    @(negedge clk);
    err_inject = 1'b0;
    wait_idle(1000);
    chk_results();
    chk_gaps(2, 20);

    // run dropped during frame 2
    fb = frames_seen;
    push_frame(64, 0);
    push_frame(64, 0);
    start_run(64, 12, 0);
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      n++;
      if (frames_seen == fb + 2 && byte_idx >= PRE_LEN + 4)
        break;
    end
    @(negedge clk);
    run = 1'b0;
    chk("drop_frame", 32'(frames_seen), 32'(fb + 2));
    wait_en(1'b0, 200, "drop_end");
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("gap_busy", 32'(n), 32'd11);
    repeat (20) @(negedge clk);
    chk_results();
    chk("drop_done", 32'(done), 32'd0);
    chk_gaps(1, 12);

    // reset in the middle of a frame
    fb = frames_seen;
    push_frame(64, 0);
    start_run(64, 12, 0);
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      n++;
      if (frames_seen == fb + 1 && byte_idx >= PRE_LEN + 11)
        break;
    end
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_en", 32'(gmii_en), 32'd0);
    chk("mid_d", 32'(gmii_d), 32'd0);
    chk("mid_er", 32'(gmii_er), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_pkts", pkts_sent, 32'd0);
    chk("mid_oct", octets_sent, 32'd0);
    exp_q.delete();
    gaps.delete();
    have_prev    = 0;
    exp_pkts     = '0;
    exp_oct      = '0;
    frames_limit = 32'd1;
    push_frame(64, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rel_c1", 32'(gmii_en), 32'd0);
    @(negedge clk);
    chk("rel_c2", 32'(gmii_en), 32'd0);
    @(negedge clk);
    chk("rel_c3", 32'(gmii_en), 32'd1);
    chk("rel_pkts", pkts_sent, 32'd1);
    wait_idle(1000);
    chk_results();
    chk("rel_done", 32'(done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
